// File: rtl/mdu_pkg.sv
// mdu_pkg: op/state encodings, default latencies and op-class helpers for the MDU.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU become timed multiply-class ops).
package mdu_pkg;
  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  function automatic logic is_mul_op(input logic [3:0] op);
    logic m;
    m = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    m = m || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return m;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit MDU result {hi,lo} for the given op.
// Ports: op (4b op code), src_a/src_b (32b operands), hi/lo (current HI/LO),
//        res (64b {hi,lo} to commit; equals {hi,lo} when nothing should change).
// Optional feature macro: MDU_MADD_EN adds the multiply-accumulate ops.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, quot, rem;
  always_comb begin
    // low 64 bits of the sign-extended product are the signed product
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    // signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
    a_neg  = (op == OP_DIV) && src_a[31];
    b_neg  = (op == OP_DIV) && src_b[31];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -src_b : src_b;
    div_b  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / div_b;
    r_mag  = a_mag % div_b;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
    res    = {hi, lo};
    if (op == OP_MULT) res = prod_s;
    else if (op == OP_MULTU) res = prod_u;
    else if (is_div_op(op) && src_b != 32'd0) res = {rem, quot};
`ifdef MDU_MADD_EN
    else if (op == OP_MADD) res = {hi, lo} + prod_s;
    else if (op == OP_MADDU) res = {hi, lo} + prod_u;
    else if (op == OP_MSUB) res = {hi, lo} - prod_s;
    else if (op == OP_MSUBU) res = {hi, lo} - prod_u;
`endif
  end
endmodule

// File: rtl/mdu_controller.sv
// mdu_controller: E-stage multiply/divide sequencer owning HI/LO, with hazard stall request.
// Ports: clk, reset (async active-low), start/op/src_a/src_b (E-stage MDU op),
//        md_class_d (D-stage MDU-class instr), busy, stall_req, hi, lo.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops on the multiply path).
module mdu_controller
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_class_d,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  logic [63:0]      res;
  mdu_arith u_arith (
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi    (hi_q),
    .lo    (lo_q),
    .res   (res)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == ST_IDLE) begin
      if (start && is_mul_op(op)) begin
        state_d = ST_MUL;
        cnt_d   = CNT_W'(MULT_CYCLES);
        pend_d  = res;
      end else if (start && is_div_op(op)) begin
        state_d = ST_DIV;
        cnt_d   = CNT_W'(DIV_CYCLES);
        pend_d  = res;
      end else if (start && op == OP_MTHI) begin
        hi_d = src_a;
      end else if (start && op == OP_MTLO) begin
        lo_d = src_a;
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d      = ST_IDLE;
        {hi_d, lo_d} = pend_q;
      end
    end
    busy_d = state_d != ST_IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end
  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = md_class_d & (busy_q | (start & (is_mul_op(op) | is_div_op(op))));
endmodule

// File: tb/tb_mdu_controller.sv
// tb_mdu_controller: randomized scoreboard bench for mdu_controller against a behavioural model.
module tb_mdu_controller;
  import mdu_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, md_class_d = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;
  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          lat;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0, errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  mdu_controller dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .md_class_d (md_class_d),
    .busy       (busy),
    .stall_req  (stall_req),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: returns busy latency (0 = untimed) and updates h/l to the architectural result.
  function automatic int model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                               inout logic [31:0] h, inout logic [31:0] l);
    longint sa, sbv, ua, ub, r, q, m;
    sa = $signed(a);
    sbv = $signed(b);
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r = {h, l};
    case (o)
      OP_MULT:  begin r = sa * sbv; {h, l} = r; return MC; end
      OP_MULTU: begin r = ua * ub; {h, l} = r; return MC; end
      OP_DIV: begin
        if (b != 0) begin q = sa / sbv; m = sa % sbv; h = m[31:0]; l = q[31:0]; end
        return DC;
      end
      OP_DIVU: begin
        if (b != 0) begin q = ua / ub; m = ua % ub; h = m[31:0]; l = q[31:0]; end
        return DC;
      end
      OP_MTHI: begin h = a; return 0; end
      OP_MTLO: begin l = a; return 0; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin r = r + sa * sbv; {h, l} = r; return MC; end
      OP_MADDU: begin r = r + ua * ub; {h, l} = r; return MC; end
      OP_MSUB:  begin r = r - sa * sbv; {h, l} = r; return MC; end
      OP_MSUBU: begin r = r - ua * ub; {h, l} = r; return MC; end
`endif
      default: return 0;
    endcase
  endfunction

  // Monitor: on every busy fall, pop and compare result and busy duration.
  int   bcnt = 0;
  logic prev = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      bcnt = 0;
      prev = 1'b0;
    end else begin
      if (busy) bcnt++;
      else if (prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: busy fell with no op outstanding");
        end else begin
          e = sb.pop_front();
          chk("result_hi", hi, e.h);
          chk("result_lo", lo, e.l);
          chk("busy_cycles", bcnt, e.lat);
        end
        bcnt = 0;
      end
      prev = busy;
    end
  end

  task automatic drain(input bit md);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      if (busy) chk("stall_busy", stall_req, md);
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d ops still outstanding, required 0", sb.size());
      sb.delete();
    end
    chk("hi_idle", hi, m_hi);
    chk("lo_idle", lo, m_lo);
    chk("stall_idle", stall_req, 1'b0);
  endtask

  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit md);
    logic [31:0] h, l;
    int lat;
    h = m_hi;
    l = m_lo;
    lat = model(o, a, b, h, l);
    start = 1'b1; op = o; src_a = a; src_b = b; md_class_d = md;
    #1 chk("stall_issue", stall_req, md && lat != 0);
    @(posedge clk);
    #1 start = 1'b0; op = OP_NONE;
    m_hi = h;
    m_lo = l;
    if (lat != 0) begin
      sb.push_back('{h: h, l: l, lat: lat});
      chk("busy_after_start", busy, 1'b1);
      drain(md);
    end else begin
      chk("busy_untimed", busy, 1'b0);
      chk("hi_untimed", hi, m_hi);
      chk("lo_untimed", lo, m_lo);
    end
  endtask

  initial begin
    logic [31:0] h, l;
    int lat;
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    do_op(OP_MULT,  32'hFFFFFFFE, 32'd3, 1'b1);
    do_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b0);
    do_op(OP_DIV,   32'hFFFFFFF9, 32'd2, 1'b1);
    do_op(OP_DIVU,  32'd7, 32'd0, 1'b0);
    do_op(OP_MTHI,  32'h12345678, 32'd0, 1'b1);
    do_op(OP_MTLO,  32'h9ABCDEF0, 32'd0, 1'b0);
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
    do_op(OP_NONE,  32'h11111111, 32'h22222222, 1'b1);
    do_op(4'd11,    32'h33333333, 32'h44444444, 1'b1);
    // second start during a divide must be ignored
    h = m_hi;
    l = m_lo;
    lat = model(OP_DIV, 32'd100, 32'hFFFFFFFD, h, l);
    start = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'hFFFFFFFD; md_class_d = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; op = OP_NONE;
    m_hi = h;
    m_lo = l;
    sb.push_back('{h: h, l: l, lat: lat});
    repeat (3) @(posedge clk);
    #1 start = 1'b1; op = OP_MULT; src_a = 32'd5; src_b = 32'd6;
    #1 chk("stall_second_start", stall_req, 1'b1);
    @(posedge clk);
    #1 start = 1'b0; op = OP_NONE;
    drain(1'b1);
    // accumulate path (no effect unless MDU_MADD_EN)
    do_op(OP_MTHI,  32'd0, 32'd0, 1'b0);
    do_op(OP_MTLO,  32'hFFFFFFFF, 32'd0, 1'b0);
    do_op(OP_MADDU, 32'd1, 32'd1, 1'b1);
    do_op(OP_MSUB,  32'hFFFFFFFF, 32'd7, 1'b0);
    // reset in the middle of a multiply discards the pending result
    start = 1'b1; op = OP_MULT; src_a = 32'h00010000; src_b = 32'h00010000; md_class_d = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; op = OP_NONE;
    sb.push_back('{h: 32'd1, l: 32'd0, lat: MC});
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    chk("midreset_stall", stall_req, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_hi", hi, 32'd0);
    chk("post_reset_lo", lo, 32'd0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
      do_op(4'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 1)));
    end
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
